// File: rtl/jk_bank_sched_pkg.sv
// rtl/jk_bank_sched_pkg.sv - shared opcodes and FSM state encoding for jk_bank_sched
//
// Purpose: opcode constants decoded by the sequencer and the state type
//          used by its FSM.
// Ports:   none (package).
// Options: JKSCH_FIXED_PRIO_EN is consumed by jk_bank_sched, not here.
package jk_bank_sched_pkg;

   localparam logic [2:0] OP_HOLD = 3'd0;
   localparam logic [2:0] OP_SET  = 3'd1;
   localparam logic [2:0] OP_CLR  = 3'd2;
   localparam logic [2:0] OP_TGL  = 3'd3;
   localparam logic [2:0] OP_LOAD = 3'd4;
   localparam logic [2:0] OP_INC  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/jk_bank_sched_jk_cell.sv
// rtl/jk_bank_sched_jk_cell.sv - one JK storage bit built from a T flip-flop
//
// Purpose: single bank cell; JK inputs are converted to a toggle enable
//          T = (J & ~Q) | (K & Q), so J=K=1 toggles, J=1 sets, K=1 clears.
// Ports:   clk  - rising-edge clock
//          rst  - synchronous active-high clear (q -> 0)
//          j, k - JK inputs
//          q    - stored bit
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   logic t;

   assign t = (j & ~q) | (k & q);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         q <= q ^ t;
      end
   end

endmodule

// File: rtl/jk_bank_sched.sv
// rtl/jk_bank_sched.sv - two-port command sequencer and arbiter for a JK flip-flop bank
//
// Purpose: arbitrates SET/CLR/TGL/LOAD/INC commands from two requesters,
//          drives per-bit J/K into a W-bit bank of jk_cell instances,
//          sequences INC bursts and returns a one-cycle ack per command.
// Ports:   clk, rst                    - clock, synchronous active-high reset
//          req0/cmd0/arg0/rep0 -> ack0 - requester 0 command and completion pulse
//          req1/cmd1/arg1/rep1 -> ack1 - requester 1 command and completion pulse
//          j, k                        - J/K vectors driven into the bank
//          q, qb                       - bank state and its complement
//          busy                        - FSM is not in IDLE
// Options: JKSCH_FIXED_PRIO_EN - requester 0 always wins simultaneous
//          requests and no round-robin pointer is kept.
module jk_bank_sched #(
   parameter int W  = 4,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic [2:0]    cmd0,
   input  logic [W-1:0]  arg0,
   input  logic [RW-1:0] rep0,
   output logic          ack0,
   input  logic          req1,
   input  logic [2:0]    cmd1,
   input  logic [W-1:0]  arg1,
   input  logic [RW-1:0] rep1,
   output logic          ack1,
   output logic [W-1:0]  j,
   output logic [W-1:0]  k,
   output logic [W-1:0]  q,
   output logic [W-1:0]  qb,
   output logic          busy
);

   import jk_bank_sched_pkg::*;

   state_t        state, state_nx;
   logic          win, win_nx;
   logic [2:0]    cmd_r, cmd_nx;
   logic [W-1:0]  arg_r, arg_nx;
   logic [RW-1:0] cnt, cnt_nx;
   logic          grant1;
   logic [2:0]    sel_cmd;
   logic [W-1:0]  inc_t;

   // Bit i toggles on increment when every lower bit is already one.
   assign inc_t[0] = 1'b1;
   for (genvar gi = 1; gi < W; gi++) begin : g_inc
      assign inc_t[gi] = &q[gi-1:0];
   end

`ifdef JKSCH_FIXED_PRIO_EN
   assign grant1 = ~req0;
`else
   logic rr, rr_nx;

   // Pointer only matters on a tie; a lone request always wins.
   assign grant1 = (req0 & req1) ? rr : req1;
`endif

   assign sel_cmd = grant1 ? cmd1 : cmd0;

   always_comb begin
      state_nx = state;
      win_nx   = win;
      cmd_nx   = cmd_r;
      arg_nx   = arg_r;
      cnt_nx   = cnt;
      j        = '0;
      k        = '0;
      ack0     = 1'b0;
      ack1     = 1'b0;
`ifndef JKSCH_FIXED_PRIO_EN
      rr_nx    = rr;
`endif
      case (state)
         ST_IDLE: begin
            if (req0 | req1) begin
               win_nx   = grant1;
               cmd_nx   = sel_cmd;
               arg_nx   = grant1 ? arg1 : arg0;
               cnt_nx   = (sel_cmd == OP_INC) ? (grant1 ? rep1 : rep0) : '0;
               state_nx = ST_APPLY;
            end
         end
         ST_APPLY: begin
            case (cmd_r)
               OP_SET:  begin j = arg_r;  k = '0;     end
               OP_CLR:  begin j = '0;     k = arg_r;  end
               OP_TGL:  begin j = arg_r;  k = arg_r;  end
               OP_LOAD: begin j = arg_r;  k = ~arg_r; end
               OP_INC:  begin j = inc_t;  k = inc_t;  end
               default: begin j = '0;     k = '0;     end
            endcase
            // cnt holds the remaining extra INC steps after this one.
            if (cmd_r == OP_INC && cnt != '0) begin
               cnt_nx = cnt - RW'(1);
            end else begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            ack0     = ~win;
            ack1     = win;
`ifndef JKSCH_FIXED_PRIO_EN
            rr_nx    = ~win;
`endif
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         win   <= 1'b0;
         cmd_r <= OP_HOLD;
         arg_r <= '0;
         cnt   <= '0;
`ifndef JKSCH_FIXED_PRIO_EN
         rr    <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         win   <= win_nx;
         cmd_r <= cmd_nx;
         arg_r <= arg_nx;
         cnt   <= cnt_nx;
`ifndef JKSCH_FIXED_PRIO_EN
         rr    <= rr_nx;
`endif
      end
   end

   for (genvar gb = 0; gb < W; gb++) begin : g_bank
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (j[gb]),
         .k   (k[gb]),
         .q   (q[gb])
      );
   end

   assign qb   = ~q;
   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_jk_bank_sched.sv
// tb/tb_jk_bank_sched.sv - self-checking bench for jk_bank_sched against a behavioural model
module tb_jk_bank_sched;

   localparam int W  = 4;
   localparam int RW = 3;
   localparam int C_SET = 1, C_CLR = 2, C_TGL = 3, C_LOAD = 4, C_INC = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1;
   logic [2:0]    cmd0, cmd1;
   logic [W-1:0]  arg0, arg1;
   logic [RW-1:0] rep0, rep1;
   logic          ack0, ack1, busy;
   logic [W-1:0]  j, k, q, qb;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] mq;
   bit           mrr;

   jk_bank_sched #(.W(W), .RW(RW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .cmd0(cmd0), .arg0(arg0), .rep0(rep0), .ack0(ack0),
      .req1(req1), .cmd1(cmd1), .arg1(arg1), .rep1(rep1), .ack1(ack1),
      .j(j), .k(k), .q(q), .qb(qb), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Effect of one complete command on the bank value.
   function automatic logic [W-1:0] model_apply(logic [W-1:0] cur, int cmd,
                                                logic [W-1:0] arg, int rep);
      case (cmd)
         C_SET:   return cur | arg;
         C_CLR:   return cur & ~arg;
         C_TGL:   return cur ^ arg;
         C_LOAD:  return arg;
         C_INC:   return W'(int'(cur) + rep + 1);
         default: return cur;
      endcase
   endfunction

   function automatic int model_win(bit r0, bit r1);
`ifdef JKSCH_FIXED_PRIO_EN
      return r1 && !r0 ? 1 : 0;
`else
      if (r0 && r1) return mrr ? 1 : 0;
      return r0 ? 0 : 1;
`endif
   endfunction

   function automatic int model_lat(int cmd, int rep);
      return ((cmd == C_INC) ? rep + 1 : 1) + 1;
   endfunction

   task automatic drive(input int port, input int cmd, input logic [W-1:0] arg, input int rep);
      if (port == 0) begin
         req0 = 1'b1; cmd0 = 3'(cmd); arg0 = arg; rep0 = RW'(rep);
      end else begin
         req1 = 1'b1; cmd1 = 3'(cmd); arg1 = arg; rep1 = RW'(rep);
      end
   endtask

   // Waits (bounded) for the first ack; who=-1 on timeout, 2 if both fired.
   // Drops the acked request, then steps once more so the DUT is back in IDLE.
   task automatic wait_ack(output int who, output int lat);
      int c;
      who = -1;
      lat = -1;
      c   = 0;
      while (who < 0 && c < 40) begin
         tick();
         c++;
         if (ack0 && ack1) who = 2;
         else if (ack0)    who = 0;
         else if (ack1)    who = 1;
      end
      if (who >= 0) begin
         lat = c;
         if (who != 1) req0 = 1'b0;
         if (who != 0) req1 = 1'b0;
         tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      mq  = '0;
      mrr = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (q !== '0) begin failures++; $display("FAIL reset_q got=%b exp=%b", q, 4'b0000); end
      checks++; if (qb !== '1) begin failures++; $display("FAIL reset_qb got=%b exp=%b", qb, 4'b1111); end
      checks++; if (j !== '0 || k !== '0) begin failures++; $display("FAIL reset_jk got=%b/%b exp=0000/0000", j, k); end
      checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b%b exp=00", ack0, ack1); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_set();
      int who, lat;
      drive(0, C_SET, 4'b0101, 0);
      tick();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL set_busy got=%b exp=1", busy); end
      checks++; if (j !== 4'b0101 || k !== 4'b0000) begin failures++; $display("FAIL set_jk got=%b/%b exp=0101/0000", j, k); end
      checks++; if (q !== mq) begin failures++; $display("FAIL set_q_before got=%b exp=%b", q, mq); end
      wait_ack(who, lat);
      mq  = model_apply(mq, C_SET, 4'b0101, 0);
      mrr = (who == 0);
      checks++; if (who !== 0 || lat !== 1) begin failures++; $display("FAIL set_ack who=%0d lat=%0d exp who=0 lat=1", who, lat); end
      checks++; if (q !== mq || qb !== ~mq) begin failures++; $display("FAIL set_q got=%b/%b exp=%b", q, qb, mq); end
      checks++; if (busy !== 1'b0 || ack0 !== 1'b0) begin failures++; $display("FAIL set_idle busy=%b ack0=%b exp 0/0", busy, ack0); end
   endtask

   task automatic test_tgl_load();
      int who, lat;
      drive(1, C_TGL, 4'b1111, 0);
      wait_ack(who, lat);
      mq = model_apply(mq, C_TGL, 4'b1111, 0); mrr = (who == 0);
      checks++; if (who !== 1 || lat !== model_lat(C_TGL, 0)) begin failures++; $display("FAIL tgl_ack who=%0d lat=%0d exp who=1", who, lat); end
      checks++; if (q !== mq) begin failures++; $display("FAIL tgl_q got=%b exp=%b", q, mq); end
      drive(1, C_LOAD, 4'b0011, 0);
      wait_ack(who, lat);
      mq = model_apply(mq, C_LOAD, 4'b0011, 0); mrr = (who == 0);
      checks++; if (who !== 1) begin failures++; $display("FAIL load_ack who=%0d exp=1", who); end
      checks++; if (q !== mq || qb !== ~mq) begin failures++; $display("FAIL load_q got=%b/%b exp=%b/%b", q, qb, mq, ~mq); end
   endtask

   task automatic test_inc();
      int who, lat;
      logic [W-1:0] tog;
      drive(0, C_LOAD, 4'b1110, 0);
      wait_ack(who, lat);
      mq = model_apply(mq, C_LOAD, 4'b1110, 0); mrr = (who == 0);
      checks++; if (q !== mq) begin failures++; $display("FAIL inc_preload got=%b exp=%b", q, mq); end
      drive(0, C_INC, 4'b1010, 3);
      for (int e = 1; e <= 5; e++) begin
         tick();
         if (e >= 2) begin
            mq = W'(mq + 1'b1);
            checks++; if (q !== mq) begin failures++; $display("FAIL inc_step%0d got=%b exp=%b", e, q, mq); end
         end
         if (e <= 4) begin
            tog = mq ^ W'(mq + 1'b1);
            checks++; if (j !== tog || k !== tog) begin failures++; $display("FAIL inc_jk%0d got=%b/%b exp=%b", e, j, k, tog); end
         end
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL inc_busy%0d got=%b exp=1", e, busy); end
         checks++; if (ack0 !== (e == 5) || ack1 !== 1'b0) begin failures++; $display("FAIL inc_ack%0d got=%b%b exp=%b0", e, ack0, ack1, (e == 5)); end
      end
      req0 = 1'b0;
      mrr  = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || ack0 !== 1'b0) begin failures++; $display("FAIL inc_end busy=%b ack0=%b exp 0/0", busy, ack0); end
   endtask

   task automatic test_arb();
      int who, lat, exp_who;
      do_reset();
      for (int ep = 0; ep < 2; ep++) begin
         drive(0, C_SET, 4'b0001, 0);
         drive(1, C_SET, 4'b0010, 0);
         exp_who = model_win(1'b1, 1'b1);
         wait_ack(who, lat);
         req0 = 1'b0; req1 = 1'b0;
         mq  = model_apply(mq, C_SET, (exp_who == 0) ? 4'b0001 : 4'b0010, 0);
         mrr = (exp_who == 0);
         checks++; if (who !== exp_who) begin failures++; $display("FAIL arb_grant%0d got=%0d exp=%0d", ep, who, exp_who); end
         checks++; if (q !== mq) begin failures++; $display("FAIL arb_q%0d got=%b exp=%b", ep, q, mq); end
      end
   endtask

   task automatic test_abort();
      bit saw;
      do_reset();
      drive(0, C_INC, 4'b0000, 7);
      tick(); tick(); tick();
      checks++; if (q !== 4'd2 || busy !== 1'b1) begin failures++; $display("FAIL abort_pre q=%b busy=%b exp 0010/1", q, busy); end
      rst = 1'b1; req0 = 1'b0;
      tick();
      mq = '0; mrr = 1'b0;
      checks++; if (q !== '0 || qb !== '1) begin failures++; $display("FAIL abort_q got=%b/%b exp=0000/1111", q, qb); end
      checks++; if (busy !== 1'b0 || j !== '0 || k !== '0) begin failures++; $display("FAIL abort_state busy=%b j=%b k=%b exp 0", busy, j, k); end
      rst = 1'b0;
      saw = (ack0 | ack1);
      for (int c = 0; c < 6; c++) begin
         tick();
         saw |= (ack0 | ack1);
      end
      checks++; if (saw !== 1'b0) begin failures++; $display("FAIL abort_noack saw ack=%b exp=0", saw); end
   endtask

   task automatic test_illegal_op();
      int who, lat;
      drive(1, C_LOAD, 4'b1010, 0);
      wait_ack(who, lat);
      mq = model_apply(mq, C_LOAD, 4'b1010, 0); mrr = (who == 0);
      drive(0, 6, 4'b1111, 5);
      wait_ack(who, lat);
      mrr = (who == 0);
      checks++; if (who !== 0 || lat !== model_lat(6, 5)) begin failures++; $display("FAIL op6_ack who=%0d lat=%0d exp 0/2", who, lat); end
      checks++; if (q !== mq) begin failures++; $display("FAIL op6_q got=%b exp=%b", q, mq); end
      drive(1, 7, 4'b1111, 0);
      wait_ack(who, lat);
      mrr = (who == 0);
      checks++; if (who !== 1 || q !== mq) begin failures++; $display("FAIL op7 who=%0d q=%b exp 1/%b", who, q, mq); end
   endtask

   task automatic test_random();
      int who, lat, ew, c0, c1, p0, p1;
      logic [W-1:0] a0, a1;
      bit r0, r1;
      int r;
      do_reset();
      for (int it = 0; it < 40; it++) begin
         r  = $urandom_range(1, 3);
         r0 = r[0]; r1 = r[1];
         c0 = $urandom_range(0, 7); c1 = $urandom_range(0, 7);
         p0 = $urandom_range(0, 7); p1 = $urandom_range(0, 7);
         a0 = W'($urandom); a1 = W'($urandom);
         if (r0) drive(0, c0, a0, p0);
         if (r1) drive(1, c1, a1, p1);
         ew = model_win(r0, r1);
         wait_ack(who, lat);
         req0 = 1'b0; req1 = 1'b0;
         mq  = (ew == 0) ? model_apply(mq, c0, a0, p0) : model_apply(mq, c1, a1, p1);
         mrr = (ew == 0);
         checks++; if (who !== ew) begin failures++; $display("FAIL rnd%0d_who got=%0d exp=%0d", it, who, ew); end
         checks++; if (lat !== ((ew == 0) ? model_lat(c0, p0) : model_lat(c1, p1))) begin failures++; $display("FAIL rnd%0d_lat got=%0d", it, lat); end
         checks++; if (q !== mq || qb !== ~mq) begin failures++; $display("FAIL rnd%0d_q got=%b/%b exp=%b", it, q, qb, mq); end
      end
   endtask

   initial begin
      rst = 1'b1;
      req0 = 1'b0; cmd0 = '0; arg0 = '0; rep0 = '0;
      req1 = 1'b0; cmd1 = '0; arg1 = '0; rep1 = '0;
      mq = '0; mrr = 1'b0;
      test_reset();
      test_set();
      test_tgl_load();
      test_inc();
      test_arb();
      test_abort();
      test_illegal_op();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
